hdr_tonemap: RTL and testbench
==============================

# hdr_tonemap

Global linear tone-mapping stage placed directly downstream of the HDR merge block. It consumes the per-channel 8-bit log-radiance values (Q4.4) and their valid pulse, gathers the minimum and maximum over each frame, and computes a reciprocal scale with a sequential divider during blanking. The next frame is mapped onto RGB565 for the display/frame-buffer writer.

## Interface
- N, 8, log-radiance width (Q4.4, unsigned)
- DIV_W, 16, reciprocal width; numerator is 2^DIV_W-1
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  pixel valid (connected to merge-stage hdr_done)
- in_sof  in  1  first pixel of frame; qualified by in_valid
- in_eof  in  1  last pixel of frame; qualified by in_valid
- lE_red, lE_green, lE_blue  in  N  log radiance per channel
- out_valid  out  1  mapped pixel valid
- out_sof, out_eof  out  1  in_sof/in_eof delayed with the pixel
- out_red  out  5  mapped red
- out_green  out  6  mapped green
- out_blue  out  5  mapped blue
- late_frame  out  1  one-cycle pulse: SOF arrived before new parameters were ready

## Operation
- Active parameters: act_min (N) and act_recip (DIV_W). Reset values are 0 and 257, which gives identity mapping.
- Map per channel:
  - d = lE − act_min, clamped to [0, act_range]
  - norm = (d × act_recip) >> 8, saturated to 255
  - out_red = norm[7:3], out_green = norm[7:2], out_blue = norm[7:3]
- Stats:
  - On in_valid&in_sof, run_min and run_max are loaded with the min and max of the three channels of that pixel.
  - Every other valid pixel updates run_min and run_max across all three channels.
  - On in_valid&in_eof, pend_min and pend_range are latched from stats that include the eof pixel.
- Divider FSM (IDLE, DIVIDE, READY):
  - IDLE→DIVIDE on eof.
  - DIVIDE runs 16 cycles of restoring division computing floor(65535/pend_range), then goes to READY.
  - If pend_range==0, the result is forced to 0, so the whole next frame maps to 0.
  - READY→IDLE on in_valid&in_sof. On that transition, act_min, act_range and act_recip load the pending values, and the sof pixel already uses them.
- Boundary cases:
  - SOF during DIVIDE: old parameters stay active, late_frame pulses, the FSM stays in DIVIDE. The result applies at the following SOF.
  - EOF during DIVIDE: the divide restarts with the new stats (count reset, previous result dropped).
  - EOF in READY: pending values are overwritten and the FSM re-enters DIVIDE.
  - SOF and EOF on the same pixel: SOF handling first, then the single-pixel stats are latched and DIVIDE starts.
  - Gaps in in_valid are allowed anywhere. Stats and the pipeline advance only on valid pixels; the pipeline register valid bits shift every cycle.
- Reset mid-operation: FSM→IDLE, parameters→identity, pipeline valid bits cleared. Pixels in flight are lost.

## Timing
- Latency is 3 cycles, in_valid→out_valid:
  - S1: subtract/clamp
  - S2: multiply
  - S3: shift, saturate, truncate into output registers
- Throughput is 1 pixel/cycle.
- Reset values of outputs:
  - out_valid, out_sof, out_eof, late_frame = 0
  - out_red, out_green, out_blue = 0
- With EOF at cycle t: DIVIDE runs t+1..t+16, READY at t+17. Blanking must be ≥17 cycles for on-time parameter update.
- late_frame is asserted in the same cycle the offending SOF is sampled.

## Structure
- Shared package hdr_defs holds:
  - N and FP=4
  - channel widths 5/6/5
  - DIV_W, RESET_RECIP=257
  - FSM state encodings
- One sub-module, recip_div: sequential restoring divider.
  - Ports: start, range[N-1:0], busy, done, quotient[DIV_W-1:0].
  - A new start while busy restarts it.
- Top level contains the stats logic, FSM control and 3-stage map pipeline.

## Test plan
- After reset, stream lE=0x80 on all channels → 3 cycles later out_red=16, out_green=32, out_blue=16 (identity).
- Frame spanning 0x20..0x60, 40 blanking cycles, next frame:
  - Reciprocal is 1023.
  - lE 0x60 → 31/63/31; 0x20 → 0/0/0.
  - 0x10 clamps to 0; 0x70 saturates to 31/63/31.
- Flat frame of 0x40 → range 0 → every pixel of the next frame outputs 0/0/0.
- SOF 5 cycles after EOF → late_frame=1 for one cycle, that frame uses old parameters, new ones apply at the following SOF.
- Second EOF 8 cycles into DIVIDE → READY exactly 17 cycles after the second EOF, with the second frame's stats.
- rst asserted during DIVIDE and mid-stream → next cycle out_valid=0 and FSM IDLE; subsequent lE=0x80 maps to 16/32/16.

Source files
------------

// File: rtl/hdr_tonemap_pkg.sv
// Shared constants, FSM encoding and small arithmetic helpers for the HDR tone-mapping stage.
package hdr_defs;
  localparam int N           = 8;
  localparam int FP          = 4;
  localparam int R_W         = 5;
  localparam int G_W         = 6;
  localparam int B_W         = 5;
  localparam int DIV_W       = 16;
  localparam int RESET_RECIP = 257;
  localparam int PW          = N + DIV_W;
  localparam int NORM_SH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_READY  = 2'd2
  } div_state_t;

  function automatic logic [N-1:0] min2(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [N-1:0] max2(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [N-1:0] clamp_sub(input logic [N-1:0] le, input logic [N-1:0] mn,
                                             input logic [N-1:0] rng);
    logic [N-1:0] d;
    d = le - mn;
    if (le < mn) return '0;
    return (d > rng) ? rng : d;
  endfunction

  function automatic logic [N-1:0] sat_norm(input logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = p >> NORM_SH;
    return (|s[PW-1:N]) ? '1 : s[N-1:0];
  endfunction
endpackage

// File: rtl/hdr_tonemap_recip_div.sv
// Sequential restoring divider: floor((2^DIV_W-1) / range), one quotient bit per cycle.
module recip_div
  import hdr_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     range,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CW = $clog2(DIV_W);

  logic [N-1:0]     divisor;
  logic [N-1:0]     rem;
  logic [DIV_W-1:0] q;
  logic [CW-1:0]    count;
  logic [N:0]       trial;
  logic [N:0]       rem_next;
  logic             fit;

  // The numerator is all ones, so every step brings a 1 into the partial remainder.
  always_comb begin
    trial    = {rem, 1'b1};
    fit      = (trial >= {1'b0, divisor});
    rem_next = fit ? (trial - {1'b0, divisor}) : trial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      count   <= '0;
      rem     <= '0;
      q       <= '0;
      divisor <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      rem     <= '0;
      q       <= '0;
      divisor <= range;
    end else if (busy) begin
      rem   <= rem_next[N-1:0];
      q     <= {q[DIV_W-2:0], fit};
      count <= count + CW'(1);
      if (count == CW'(DIV_W - 1)) busy <= 1'b0;
    end
  end

  assign done     = busy && (count == CW'(DIV_W - 1));
  // A zero range would divide by zero; a zero reciprocal maps the whole next frame to black.
  assign quotient = (divisor == '0) ? '0 : q;
endmodule

// File: rtl/hdr_tonemap.sv
// Global linear tone mapper: per-frame min/max stats, reciprocal computed in blanking,
// 3-stage map of Q4.4 log radiance onto RGB565.
module hdr_tonemap
  import hdr_defs::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic           in_eof,
  input  logic [N-1:0]   lE_red,
  input  logic [N-1:0]   lE_green,
  input  logic [N-1:0]   lE_blue,
  output logic           out_valid,
  output logic           out_sof,
  output logic           out_eof,
  output logic [R_W-1:0] out_red,
  output logic [G_W-1:0] out_green,
  output logic [B_W-1:0] out_blue,
  output logic           late_frame,
  output logic [1:0]     fsm_state
);
  div_state_t state, state_next;

  logic             sof_px, eof_px, load_act;
  logic [N-1:0]     pix_min, pix_max, new_min, new_max, stat_range;
  logic [N-1:0]     run_min, run_max, pend_min, pend_range;
  logic [N-1:0]     act_min, act_range, use_min, use_range;
  logic [DIV_W-1:0] act_recip, use_recip;
  logic             div_busy, div_done;
  logic [DIV_W-1:0] div_quotient;

  logic             s1_valid, s1_sof, s1_eof;
  logic [N-1:0]     s1_d_r, s1_d_g, s1_d_b;
  logic [DIV_W-1:0] s1_recip;
  logic             s2_valid, s2_sof, s2_eof;
  logic [PW-1:0]    s2_p_r, s2_p_g, s2_p_b;
  logic [N-1:0]     n_r, n_g, n_b;

  assign sof_px = in_valid & in_sof;
  assign eof_px = in_valid & in_eof;

  // An SOF pixel restarts the running stats from its own channels.
  always_comb begin
    pix_min    = min2(lE_red, min2(lE_green, lE_blue));
    pix_max    = max2(lE_red, max2(lE_green, lE_blue));
    new_min    = sof_px ? pix_min : min2(run_min, pix_min);
    new_max    = sof_px ? pix_max : max2(run_max, pix_max);
    stat_range = new_max - new_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min    <= '0;
      run_max    <= '0;
      pend_min   <= '0;
      pend_range <= '0;
    end else if (in_valid) begin
      run_min <= new_min;
      run_max <= new_max;
      if (in_eof) begin
        pend_min   <= new_min;
        pend_range <= stat_range;
      end
    end
  end

  recip_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (eof_px),
    .range    (stat_range),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // EOF wins over every other event: it always (re)starts a divide on the latest stats.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (eof_px) state_next = ST_DIVIDE;
      ST_DIVIDE: if (eof_px) state_next = ST_DIVIDE;
                 else if (div_done) state_next = ST_READY;
      ST_READY:  if (eof_px) state_next = ST_DIVIDE;
                 else if (sof_px) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load_act   = (state == ST_READY) && sof_px;
    late_frame = !rst && sof_px && div_busy;
    fsm_state  = state;
  end

  // The SOF pixel that triggers the load is already mapped with the new parameters.
  always_comb begin
    use_min   = load_act ? pend_min     : act_min;
    use_range = load_act ? pend_range   : act_range;
    use_recip = load_act ? div_quotient : act_recip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_min   <= '0;
      act_range <= '1;
      act_recip <= DIV_W'(RESET_RECIP);
    end else if (load_act) begin
      act_min   <= pend_min;
      act_range <= pend_range;
      act_recip <= div_quotient;
    end
  end

  always_comb begin
    n_r = sat_norm(s2_p_r);
    n_g = sat_norm(s2_p_g);
    n_b = sat_norm(s2_p_b);
  end

  // Valid/sof/eof shift every cycle; data registers only load behind a valid pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_d_r    <= '0;
      s1_d_g    <= '0;
      s1_d_b    <= '0;
      s1_recip  <= '0;
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eof    <= 1'b0;
      s2_p_r    <= '0;
      s2_p_g    <= '0;
      s2_p_b    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_sof    <= sof_px;
      s1_eof    <= eof_px;
      s2_valid  <= s1_valid;
      s2_sof    <= s1_sof;
      s2_eof    <= s1_eof;
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      out_eof   <= s2_eof;
      if (in_valid) begin
        s1_d_r   <= clamp_sub(lE_red,   use_min, use_range);
        s1_d_g   <= clamp_sub(lE_green, use_min, use_range);
        s1_d_b   <= clamp_sub(lE_blue,  use_min, use_range);
        s1_recip <= use_recip;
      end
      if (s1_valid) begin
        s2_p_r <= PW'(s1_d_r) * PW'(s1_recip);
        s2_p_g <= PW'(s1_d_g) * PW'(s1_recip);
        s2_p_b <= PW'(s1_d_b) * PW'(s1_recip);
      end
      if (s2_valid) begin
        out_red   <= n_r[N-1 -: R_W];
        out_green <= n_g[N-1 -: G_W];
        out_blue  <= n_b[N-1 -: B_W];
      end
    end
  end
endmodule

// File: tb/tb_hdr_tonemap.sv
// Directed bench for hdr_tonemap: hand-computed RGB565 results, FSM timing and late-frame cases.
module tb_hdr_tonemap;
  import hdr_defs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic [7:0] lE_red = '0, lE_green = '0, lE_blue = '0;
  logic       out_valid, out_sof, out_eof, late_frame;
  logic [4:0] out_red, out_blue;
  logic [5:0] out_green;
  logic [1:0] fsm_state;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic        last_late = 1'b0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  hdr_tonemap dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .lE_red     (lE_red),
    .lE_green   (lE_green),
    .lE_blue    (lE_blue),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_red    (out_red),
    .out_green  (out_green),
    .out_blue   (out_blue),
    .late_frame (late_frame),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    logic [4:0] rr;
    logic [5:0] gg;
    logic [4:0] bb;
    rr = r[4:0];
    gg = g[5:0];
    bb = b[4:0];
    return {rr, gg, bb};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic sof, input logic eof, input logic [15:0] exp);
    in_valid = 1'b1;
    in_sof   = sof;
    in_eof   = eof;
    lE_red   = r;
    lE_green = g;
    lE_blue  = b;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 3);
    #1;
    last_late = late_frame;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    repeat (n) tick();
  endtask

  // Scoreboard: every mapped pixel must appear exactly 3 cycles after it was presented
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", out_valid, 1'b0);
      end else begin
        check("out_cycle", cyc, exp_cyc_q[0]);
        check("out_rgb", {out_red, out_green, out_blue}, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
      check("out_missing", out_valid, 1'b1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    idle(2);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rgb", {out_red, out_green, out_blue}, 16'd0);
    check("rst_sof_eof", {out_sof, out_eof}, 2'd0);
    check("rst_late", late_frame, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);
    rst = 1'b0;
    tick();

    // Identity mapping after reset
    send(8'h80, 8'h80, 8'h80, 1'b1, 1'b0, rgb(16, 32, 16));
    repeat (3) send(8'h80, 8'h80, 8'h80, 1'b0, 1'b0, rgb(16, 32, 16));
    idle(2);

    // Frame spanning 0x20..0x60, still mapped with identity
    send(8'h20, 8'h40, 8'h60, 1'b1, 1'b0, rgb(4, 16, 12));
    send(8'h50, 8'h30, 8'h20, 1'b0, 1'b0, rgb(10, 12, 4));
    send(8'h60, 8'h60, 8'h30, 1'b0, 1'b1, rgb(12, 24, 6));
    idle(0);
    check("b_divide", fsm_state, ST_DIVIDE);
    idle(40);
    check("b_ready", fsm_state, ST_READY);
    check("b_recip", dut.div_quotient, 16'd1023);

    // Next frame uses min 0x20, recip 1023
    send(8'h60, 8'h20, 8'h10, 1'b1, 1'b0, rgb(31, 0, 0));
    check("c_state", fsm_state, ST_IDLE);
    check("c_act_recip", dut.act_recip, 16'd1023);
    send(8'h70, 8'h60, 8'h20, 1'b0, 1'b0, rgb(31, 63, 0));
    send(8'h40, 8'h30, 8'h50, 1'b0, 1'b0, rgb(15, 15, 23));
    idle(2);

    // Flat frame of 0x40: zero range
    send(8'h40, 8'h40, 8'h40, 1'b1, 1'b0, rgb(15, 31, 15));
    send(8'h40, 8'h40, 8'h40, 1'b0, 1'b0, rgb(15, 31, 15));
    send(8'h40, 8'h40, 8'h40, 1'b0, 1'b1, rgb(15, 31, 15));
    idle(20);
    check("d_ready", fsm_state, ST_READY);
    check("d_recip_zero", dut.div_quotient, 16'd0);

    // Everything maps to black; this frame spans 0x00..0xFF
    send(8'h80, 8'hFF, 8'h00, 1'b1, 1'b0, rgb(0, 0, 0));
    send(8'h10, 8'h55, 8'hC3, 1'b0, 1'b0, rgb(0, 0, 0));
    send(8'h00, 8'hFF, 8'h80, 1'b0, 1'b1, rgb(0, 0, 0));
    idle(4);

    // SOF 5 cycles after EOF: late, old (zero) parameters stay
    send(8'h80, 8'h80, 8'h80, 1'b1, 1'b0, rgb(0, 0, 0));
    check("f_late_pulse", last_late, 1'b1);
    send(8'h40, 8'h40, 8'h40, 1'b0, 1'b0, rgb(0, 0, 0));
    check("f_late_clear", last_late, 1'b0);
    check("f_state_divide", fsm_state, ST_DIVIDE);
    idle(9);
    check("f_divide_t16", fsm_state, ST_DIVIDE);
    idle(1);
    check("f_ready_t17", fsm_state, ST_READY);
    check("f_recip", dut.div_quotient, 16'd257);
    check("f_old_recip", dut.act_recip, 16'd0);

    // Following SOF picks up the 0x00..0xFF parameters (identity again)
    send(8'h80, 8'h80, 8'h80, 1'b1, 1'b0, rgb(16, 32, 16));
    send(8'h20, 8'h44, 8'hF8, 1'b0, 1'b0, rgb(4, 17, 31));
    send(8'h50, 8'h50, 8'h50, 1'b0, 1'b1, rgb(10, 20, 10));
    idle(7);

    // Single-pixel SOF+EOF frame 8 cycles into DIVIDE restarts the divide
    send(8'h30, 8'h70, 8'h50, 1'b1, 1'b1, rgb(6, 28, 10));
    check("h_late_pulse", last_late, 1'b1);
    check("h_divide_t1", fsm_state, ST_DIVIDE);
    idle(15);
    check("h_divide_t16", fsm_state, ST_DIVIDE);
    idle(1);
    check("h_ready_t17", fsm_state, ST_READY);
    check("h_recip", dut.div_quotient, 16'd1023);

    // New frame: min 0x30, recip 1023
    send(8'h70, 8'h30, 8'h50, 1'b1, 1'b0, rgb(31, 0, 15));
    check("i_state", fsm_state, ST_IDLE);
    send(8'h40, 8'h40, 8'h40, 1'b0, 1'b1, rgb(7, 15, 7));
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    check("i_divide", fsm_state, ST_DIVIDE);

    // Reset during DIVIDE with a pixel in flight
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    tick();
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_state", fsm_state, ST_IDLE);
    check("rst2_rgb", {out_red, out_green, out_blue}, 16'd0);
    check("rst2_recip", dut.act_recip, 16'd257);
    rst = 1'b0;
    tick();
    send(8'h80, 8'h80, 8'h80, 1'b1, 1'b0, rgb(16, 32, 16));
    send(8'h20, 8'h44, 8'hF8, 1'b0, 1'b0, rgb(4, 17, 31));
    idle(6);
    check("drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
